int_csr_ctrl: RTL and testbench
===============================

Name: int_csr_ctrl

Overview:
- WB-end consumer of the MEM/WB interrupt and CSR fields: owns the IE, EPC and CAUSE registers and applies the write strobes delivered at WB.
- Edge-detects three external interrupt sources, keeps per-source pending bits and picks the highest-priority pending source.
- Raises a held interrupt request toward IF/ID carrying one-hot IRS and a handler vector.
- Completes the handshake when Int_Enter for that request retires at WB.

Parameters:
- WIDTH, 32, data/address width of EPC, CAUSE and vector.
- VEC_BASE, 32'h0000_0100, handler address for source 0.
- VEC_STRIDE, 32'h0000_0040, address step between source handlers.
- CNT_W, 16, width of taken-interrupt counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  3  raw interrupt lines; bit 2 is highest priority.
- IEWrite_wb  in  1  IE write strobe from WB.
- IEWriteData_wb  in  1  new IE value.
- EPCWrite_wb  in  1  EPC write strobe.
- EPCWriteData_wb  in  WIDTH  new EPC value.
- CAUSEWrite_wb  in  1  CAUSE write strobe.
- CAUSEWriteData_wb  in  WIDTH  new CAUSE value.
- Int_Enter_wb  in  1  interrupt-entry bubble retiring at WB.
- IRS_wb  in  3  one-hot source carried with that bubble.
- uret_wb  in  1  uret retiring at WB.
- int_cancel  in  1  pipeline flushed the in-flight interrupt bubble before WB.
- int_req  out  1  interrupt request to front end.
- int_irs  out  3  one-hot granted source.
- int_vector  out  WIDTH  handler PC.
- ie_out  out  1  current IE.
- epc_out  out  WIDTH  current EPC.
- cause_out  out  WIDTH  current CAUSE.
- pend_out  out  3  pending bits.
- int_count  out  CNT_W  interrupts taken; wraps.

Behaviour:
- Reset (async, rst=1): IE=0, EPC=0, CAUSE=0, pend=0, prev irq=0, busy=0, grant=0, int_count=0. All outputs therefore read 0 except int_vector, which reads VEC_BASE.
- Edge detect: pend[i] sets the cycle after irq_in[i] goes 0→1. A level held high does not re-set pend[i] once it is cleared.
- Grant selection: sel is the highest set bit of pend. It is combinational; it is captured into grant only when a request issues.
- Handshake FSM, state IDLE:
  - If IE=1, pend≠0 and no IE write to 0 is present this cycle: grant<=onehot(sel), go to BUSY.
  - int_req=0 in IDLE.
- Handshake FSM, state BUSY:
  - int_req=1; int_irs=grant and int_vector=VEC_BASE+idx(grant)*VEC_STRIDE, both stable throughout BUSY.
  - Int_Enter_wb=1: pend &= ~IRS_wb, int_count+=1, go to IDLE.
  - int_cancel=1 (and no Int_Enter_wb): go to IDLE with pend unchanged, so the request re-issues.
  - Int_Enter_wb and int_cancel together: Int_Enter_wb wins.
- Same-cycle pend set and clear on one bit: set wins, so a new edge is never lost.
- A higher-priority edge arriving during BUSY does not change grant; it is served after the return to IDLE.
- CSR writes take effect on the next edge.
  - IE: IEWrite_wb has priority over uret_wb; uret_wb alone sets IE=1.
  - EPC and CAUSE load on their strobes.
- IE=0 in IDLE blocks new requests. Clearing IE during BUSY does not withdraw the request; the bubble is already committed.
- int_count wraps from 2^CNT_W−1 to 0.
- int_vector when grant=0 is VEC_BASE.

Optional Feature:
- IRQ_SYNC_EN defined: irq_in passes through a two-flop synchronizer (reset to 0) before edge detection. pend sets 3 cycles after the input rises.
- IRQ_SYNC_EN undefined: irq_in feeds edge detection directly. pend sets 1 cycle after the input rises.

Test Plan:
- Reset, then IEWrite_wb=1/IEWriteData_wb=1, then pulse irq_in=3'b001 → pend_out=001; next cycle int_req=1, int_irs=001, int_vector=32'h100.
- Hold BUSY, pulse Int_Enter_wb with IRS_wb=001 → int_req=0, pend_out=000, int_count=1.
- irq_in=3'b101 together with IE=1 → grant=100, int_vector=32'h180; after Int_Enter_wb with IRS_wb=100, re-request with int_irs=001.
- In BUSY pulse int_cancel → int_req drops for one cycle and re-asserts with the same int_irs; pend unchanged.
- EPCWrite_wb with 32'h0000_0ABC and CAUSEWrite_wb with 32'h8000_0002 → epc_out and cause_out update next cycle. uret_wb together with IEWrite_wb/IEWriteData_wb=0 → ie_out=0.
- Assert rst while in BUSY with pend=011 → int_req, pend_out, ie_out and int_count drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/int_csr_ctrl.sv
// int_csr_ctrl: WB-end interrupt and CSR controller.
//
// Owns the IE, EPC and CAUSE registers and applies the CSR write strobes that
// retire at WB. Edge-detects three external interrupt lines into per-source
// pending bits, grants the highest-priority pending source and holds a request
// toward IF/ID until the matching interrupt-entry bubble retires at WB or the
// bubble is cancelled by a pipeline flush.
//
// Optional feature: define IRQ_SYNC_EN to pass irq_in through a two-flop
// synchronizer before edge detection (pend then sets 3 cycles after a rise
// instead of 1).
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   irq_in[2:0]                       raw interrupt lines, bit 2 highest priority
//   IEWrite_wb / IEWriteData_wb       IE write strobe and value
//   EPCWrite_wb / EPCWriteData_wb     EPC write strobe and value
//   CAUSEWrite_wb / CAUSEWriteData_wb CAUSE write strobe and value
//   Int_Enter_wb / IRS_wb             interrupt-entry bubble retiring, its one-hot source
//   uret_wb                           uret retiring (re-enables IE)
//   int_cancel                        in-flight interrupt bubble flushed before WB
//   int_req / int_irs / int_vector    request, granted one-hot source, handler PC
//   ie_out / epc_out / cause_out      current CSR values
//   pend_out                          pending bits
//   int_count                         taken-interrupt counter (wraps)
module int_csr_ctrl #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      VEC_BASE   = 32'h0000_0100,
  parameter logic [WIDTH-1:0]      VEC_STRIDE = 32'h0000_0040,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       irq_in,
  input  logic             IEWrite_wb,
  input  logic             IEWriteData_wb,
  input  logic             EPCWrite_wb,
  input  logic [WIDTH-1:0] EPCWriteData_wb,
  input  logic             CAUSEWrite_wb,
  input  logic [WIDTH-1:0] CAUSEWriteData_wb,
  input  logic             Int_Enter_wb,
  input  logic [2:0]       IRS_wb,
  input  logic             uret_wb,
  input  logic             int_cancel,
  output logic             int_req,
  output logic [2:0]       int_irs,
  output logic [WIDTH-1:0] int_vector,
  output logic             ie_out,
  output logic [WIDTH-1:0] epc_out,
  output logic [WIDTH-1:0] cause_out,
  output logic [2:0]       pend_out,
  output logic [CNT_W-1:0] int_count
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         prev_q;
  logic [2:0]         grant_q, grant_d;
  logic               ie_q, ie_d;
  logic [WIDTH-1:0]   epc_q, epc_d;
  logic [WIDTH-1:0]   cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         irq_s;
  logic [2:0]         rise;
  logic [2:0]         sel_oh;
  logic [2:0]         clr;
  logic               ie_block;

`ifdef IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise = irq_s & ~prev_q;

  // Fixed priority: bit 2 wins.
  always_comb begin
    sel_oh = 3'b000;
    if (pend_q[2])      sel_oh = 3'b100;
    else if (pend_q[1]) sel_oh = 3'b010;
    else if (pend_q[0]) sel_oh = 3'b001;
  end

  // An IE clear retiring this cycle must suppress a new issue.
  assign ie_block = IEWrite_wb & ~IEWriteData_wb;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    clr     = 3'b000;
    unique case (state_q)
      StIdle: begin
        if (ie_q && (pend_q != 3'b000) && !ie_block) begin
          grant_d = sel_oh;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Entry beats cancel: the bubble has already retired.
        if (Int_Enter_wb) begin
          clr     = IRS_wb;
          cnt_d   = cnt_q + 1'b1;
          state_d = StIdle;
        end else if (int_cancel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Set after clear so a fresh edge is never lost.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    ie_d = ie_q;
    if (IEWrite_wb)   ie_d = IEWriteData_wb;
    else if (uret_wb) ie_d = 1'b1;
    epc_d   = EPCWrite_wb   ? EPCWriteData_wb   : epc_q;
    cause_d = CAUSEWrite_wb ? CAUSEWriteData_wb : cause_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= 3'b000;
      prev_q  <= 3'b000;
      grant_q <= 3'b000;
      ie_q    <= 1'b0;
      epc_q   <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= irq_s;
      grant_q <= grant_d;
      ie_q    <= ie_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (grant_q)
      3'b010:  int_vector = VEC_BASE + VEC_STRIDE;
      3'b100:  int_vector = VEC_BASE + (VEC_STRIDE << 1);
      default: int_vector = VEC_BASE;
    endcase
  end

  assign int_req   = (state_q == StBusy);
  assign int_irs   = grant_q;
  assign ie_out    = ie_q;
  assign epc_out   = epc_q;
  assign cause_out = cause_q;
  assign pend_out  = pend_q;
  assign int_count = cnt_q;

endmodule

// File: tb/tb_int_csr_ctrl.sv
// Self-checking bench for int_csr_ctrl (default build, no input synchronizer).
// A small counter width is used so that counter wrap is reachable quickly.
module tb_int_csr_ctrl;

  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        IEWrite_wb, IEWriteData_wb;
  logic        EPCWrite_wb;
  logic [31:0] EPCWriteData_wb;
  logic        CAUSEWrite_wb;
  logic [31:0] CAUSEWriteData_wb;
  logic        Int_Enter_wb;
  logic [2:0]  IRS_wb;
  logic        uret_wb, int_cancel;
  logic        int_req;
  logic [2:0]  int_irs;
  logic [31:0] int_vector;
  logic        ie_out;
  logic [31:0] epc_out, cause_out;
  logic [2:0]  pend_out;
  logic [CNT_W-1:0] int_count;

  int n_cmp = 0;
  int n_err = 0;

  int_csr_ctrl #(
    .WIDTH      (32),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0040),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .irq_in            (irq_in),
    .IEWrite_wb        (IEWrite_wb),
    .IEWriteData_wb    (IEWriteData_wb),
    .EPCWrite_wb       (EPCWrite_wb),
    .EPCWriteData_wb   (EPCWriteData_wb),
    .CAUSEWrite_wb     (CAUSEWrite_wb),
    .CAUSEWriteData_wb (CAUSEWriteData_wb),
    .Int_Enter_wb      (Int_Enter_wb),
    .IRS_wb            (IRS_wb),
    .uret_wb           (uret_wb),
    .int_cancel        (int_cancel),
    .int_req           (int_req),
    .int_irs           (int_irs),
    .int_vector        (int_vector),
    .ie_out            (ie_out),
    .epc_out           (epc_out),
    .cause_out         (cause_out),
    .pend_out          (pend_out),
    .int_count         (int_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  irq;
    logic        iew, iewd, epcw;
    logic [31:0] epcd;
    logic        cw;
    logic [31:0] cd;
    logic        ent;
    logic [2:0]  irs;
    logic        uret, cancel;
  } in_t;

  typedef struct {
    logic        req;
    logic [2:0]  irs;
    logic [31:0] vec;
    logic        ie;
    logic [31:0] epc, cause;
    logic [2:0]  pend;
    logic [3:0]  cnt;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t i);
    irq_in            = i.irq;
    IEWrite_wb        = i.iew;
    IEWriteData_wb    = i.iewd;
    EPCWrite_wb       = i.epcw;
    EPCWriteData_wb   = i.epcd;
    CAUSEWrite_wb     = i.cw;
    CAUSEWriteData_wb = i.cd;
    Int_Enter_wb      = i.ent;
    IRS_wb            = i.irs;
    uret_wb           = i.uret;
    int_cancel        = i.cancel;
  endtask

  // Apply control inputs for one cycle (CSR data strobes idle), sample after the edge.
  task automatic step(input logic [2:0] irq, input logic ent, input logic [2:0] irs,
                      input logic cancel, input logic iew, input logic iewd);
    in_t i;
    i = '{irq, iew, iewd, 1'b0, 32'h0, 1'b0, 32'h0, ent, irs, 1'b0, cancel};
    drive(i);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vec_of(input logic [2:0] oh);
    case (oh)
      3'b010:  return 32'h0000_0140;
      3'b100:  return 32'h0000_0180;
      default: return 32'h0000_0100;
    endcase
  endfunction

  task automatic chk(input string name, input logic req, input logic [2:0] irs,
                     input logic [2:0] pend, input logic [3:0] cnt, input logic ie);
    cmp({name, ".req"},  {31'b0, int_req}, {31'b0, req});
    cmp({name, ".pend"}, {29'b0, pend_out}, {29'b0, pend});
    cmp({name, ".cnt"},  {28'b0, int_count}, {28'b0, cnt});
    cmp({name, ".ie"},   {31'b0, ie_out}, {31'b0, ie});
    if (req) begin
      cmp({name, ".irs"}, {29'b0, int_irs}, {29'b0, irs});
      cmp({name, ".vec"}, int_vector, vec_of(irs));
    end
  endtask

  vec_t tbl[13];

  initial begin
    in_t z;
    z = '{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0};

    //         irq     iew  iewd epcw epcd          cw   cd            ent  irs     uret cancel
    //         req  irs     vec            ie   epc           cause         pend    cnt
    tbl[0]  = '{'{3'b000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b000, 4'd0}};
    tbl[1]  = '{'{3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b001, 4'd0}};
    tbl[2]  = '{'{3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b1, 3'b001, 32'h100, 1'b1, 32'h0, 32'h0, 3'b001, 4'd0}};
    tbl[3]  = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b1, 3'b001, 32'h100, 1'b1, 32'h0, 32'h0, 3'b001, 4'd0}};
    tbl[4]  = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'b001, 1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b000, 4'd1}};
    tbl[5]  = '{'{3'b101, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b101, 4'd1}};
    tbl[6]  = '{'{3'b101, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b1, 3'b100, 32'h180, 1'b1, 32'h0, 32'h0, 3'b101, 4'd1}};
    tbl[7]  = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'b100, 1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b001, 4'd2}};
    tbl[8]  = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0},
                '{1'b1, 3'b001, 32'h100, 1'b1, 32'h0, 32'h0, 3'b001, 4'd2}};
    tbl[9]  = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'b001, 1'b0, 1'b1},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0, 32'h0, 3'b000, 4'd3}};
    tbl[10] = '{'{3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC, 1'b1, 32'h8000_0002, 1'b0, 3'b000,
                  1'b0, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b1, 32'h0000_0ABC, 32'h8000_0002, 3'b000, 4'd3}};
    tbl[11] = '{'{3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0},
                '{1'b0, 3'b000, 32'h100, 1'b0, 32'h0000_0ABC, 32'h8000_0002, 3'b000, 4'd3}};
    tbl[12] = '{'{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0},
                '{1'b1 & 1'b0, 3'b000, 32'h100, 1'b1, 32'h0000_0ABC, 32'h8000_0002, 3'b000, 4'd3}};

    rst = 1'b1;
    drive(z);
    #12;
    chk("reset", 1'b0, 3'b000, 3'b000, 4'd0, 1'b0);
    cmp("reset.vec", int_vector, 32'h0000_0100);
    cmp("reset.irs", {29'b0, int_irs}, 32'h0);
    cmp("reset.epc", epc_out, 32'h0);
    cmp("reset.cause", cause_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      string nm;
      nm = $sformatf("row%0d", k);
      drive(tbl[k].i);
      @(posedge clk);
      #1;
      cmp({nm, ".req"},   {31'b0, int_req}, {31'b0, tbl[k].o.req});
      cmp({nm, ".ie"},    {31'b0, ie_out}, {31'b0, tbl[k].o.ie});
      cmp({nm, ".epc"},   epc_out, tbl[k].o.epc);
      cmp({nm, ".cause"}, cause_out, tbl[k].o.cause);
      cmp({nm, ".pend"},  {29'b0, pend_out}, {29'b0, tbl[k].o.pend});
      cmp({nm, ".cnt"},   {28'b0, int_count}, {28'b0, tbl[k].o.cnt});
      if (tbl[k].o.req) begin
        cmp({nm, ".irs"}, {29'b0, int_irs}, {29'b0, tbl[k].o.irs});
        cmp({nm, ".vec"}, int_vector, tbl[k].o.vec);
      end
    end

    // IE clear retiring in IDLE blocks issue; clearing IE in BUSY keeps the request.
    step(3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("ieb1", 1'b0, 3'b000, 3'b100, 4'd3, 1'b1);
    step(3'b100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); chk("ieb2", 1'b0, 3'b000, 3'b100, 4'd3, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1); chk("ieb3", 1'b0, 3'b000, 3'b100, 4'd3, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("ieb4", 1'b1, 3'b100, 3'b100, 4'd3, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); chk("ieb5", 1'b1, 3'b100, 3'b100, 4'd3, 1'b0);
    step(3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0); chk("ieb6", 1'b0, 3'b000, 3'b000, 4'd4, 1'b0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1); chk("ieb7", 1'b0, 3'b000, 3'b000, 4'd4, 1'b1);

    // Cancel drops the request for one cycle, then it re-issues with the same source.
    step(3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("can1", 1'b0, 3'b000, 3'b010, 4'd4, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("can2", 1'b1, 3'b010, 3'b010, 4'd4, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0); chk("can3", 1'b0, 3'b000, 3'b010, 4'd4, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("can4", 1'b1, 3'b010, 3'b010, 4'd4, 1'b1);
    step(3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0); chk("can5", 1'b0, 3'b000, 3'b000, 4'd5, 1'b1);

    // Higher-priority edge during BUSY keeps the grant; held level does not re-pend.
    step(3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("hp1", 1'b0, 3'b000, 3'b001, 4'd5, 1'b1);
    step(3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("hp2", 1'b1, 3'b001, 3'b001, 4'd5, 1'b1);
    step(3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("hp3", 1'b1, 3'b001, 3'b101, 4'd5, 1'b1);
    step(3'b101, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0); chk("hp4", 1'b0, 3'b000, 3'b100, 4'd6, 1'b1);
    step(3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("hp5", 1'b1, 3'b100, 3'b100, 4'd6, 1'b1);
    step(3'b101, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0); chk("hp6", 1'b0, 3'b000, 3'b000, 4'd7, 1'b1);
    step(3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("hp7", 1'b0, 3'b000, 3'b000, 4'd7, 1'b1);

    // Same-cycle set and clear of one pend bit: the set wins.
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("sw1", 1'b0, 3'b000, 3'b000, 4'd7, 1'b1);
    step(3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("sw2", 1'b0, 3'b000, 3'b001, 4'd7, 1'b1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("sw3", 1'b1, 3'b001, 3'b001, 4'd7, 1'b1);
    step(3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0); chk("sw4", 1'b0, 3'b000, 3'b001, 4'd8, 1'b1);
    step(3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("sw5", 1'b1, 3'b001, 3'b001, 4'd8, 1'b1);

    // Asynchronous reset while BUSY with pend=011 clears outputs before any edge.
    step(3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); chk("ar1", 1'b1, 3'b001, 3'b011, 4'd8, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar2", 1'b0, 3'b000, 3'b000, 4'd0, 1'b0);
    cmp("ar2.epc", epc_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(z);

    // Counter wraps from 15 to 0.
    step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_cnt;
      exp_cnt = 4'(k);
      step(3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      cmp($sformatf("wrap%0d.req", k), {31'b0, int_req}, 32'd1);
      step(3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
      cmp($sformatf("wrap%0d.cnt", k), {28'b0, int_count}, {28'b0, exp_cnt});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
